// File: rtl/gaussian_blur_sep.sv
// Streaming separable binomial blur (5x5 / 11x11 per frame): horizontal taps, then vertical pass over line buffers.
// Optional rounding before the normalise shift when GAUSS_ROUND_EN is defined.
module gaussian_blur_sep #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int KMAX  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ksel,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [PIX_W-1:0] out_pix,
    output logic             err_len
);
    localparam int HW   = PIX_W + 10;
    localparam int VW   = PIX_W + 20;
    localparam int NBUF = KMAX - 1;
    localparam int CW   = $clog2(IMG_W + 1);
    localparam int BW   = $clog2(NBUF);
    localparam int RW   = $clog2(KMAX + 1);

`ifdef GAUSS_ROUND_EN
    localparam logic [VW-1:0] RND11 = VW'(2 ** 19);
    localparam logic [VW-1:0] RND5  = VW'(2 ** 7);
`else
    localparam logic [VW-1:0] RND11 = '0;
    localparam logic [VW-1:0] RND5  = '0;
`endif

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    function automatic logic [8:0] coef(input logic mode, input int i);
        logic [8:0] c;
        c = '0;
        if (mode) begin
            case (i)
                0, 10:   c = 9'd1;
                1, 9:    c = 9'd10;
                2, 8:    c = 9'd45;
                3, 7:    c = 9'd120;
                4, 6:    c = 9'd210;
                5:       c = 9'd252;
                default: c = 9'd0;
            endcase
        end else begin
            case (i)
                0, 4:    c = 9'd1;
                1, 3:    c = 9'd4;
                2:       c = 9'd6;
                default: c = 9'd0;
            endcase
        end
        return c;
    endfunction

    logic [CW-1:0]    col_q, col_d, curCol, kColM1;
    logic [RW-1:0]    row_q, row_d, curRow, kRowM1;
    logic [BW-1:0]    buf_q, buf_d, curBuf;
    logic             mode_q, mode_d, curMode;
    logic             err_q, err_d;
    logic             take, drop, accept, win, winSof;

    logic [PIX_W-1:0] hTap_q [KMAX];
    logic             s1Valid_q, s1Mode_q, s1Win_q, s1Sof_q, s1Eol_q;
    logic [CW-1:0]    s1Col_q;
    logic [BW-1:0]    s1Buf_q;
    logic [HW-1:0]    hSum;

    logic [HW-1:0]    lineBuf [NBUF][IMG_W];
    logic [HW-1:0]    rd_q [NBUF];
    logic [HW-1:0]    hSum_q;
    logic             s2Mode_q, s2Win_q, s2Sof_q, s2Eol_q;
    logic [BW-1:0]    s2Buf_q;
    logic [BW-1:0]    idx;
    logic [VW-1:0]    vSum, vRnd;

    logic             outValid_q, outSof_q, outEol_q;
    logic [PIX_W-1:0] outPix_q;

    // Frame/line tracking; a sof pixel always starts row 0 col 0 regardless of state.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        err_d   = err_q;
        take    = in_valid && (in_sof || state_q == ACTIVE);
        curCol  = in_sof ? '0 : col_q;
        curRow  = in_sof ? '0 : row_q;
        curBuf  = in_sof ? '0 : buf_q;
        curMode = in_sof ? ksel : mode_q;
        drop    = (curCol == CW'(IMG_W));
        accept  = take && !drop;
        kColM1  = curMode ? CW'(KMAX - 1) : CW'(4);
        kRowM1  = curMode ? RW'(KMAX - 1) : RW'(4);
        win     = accept && (curCol >= kColM1) && (curRow >= kRowM1);
        winSof  = win && (curCol == kColM1) && (curRow == kRowM1);
        if (take) begin
            if (in_sof) begin
                state_d = ACTIVE;
                mode_d  = ksel;
                err_d   = 1'b0;
            end
            if (drop) err_d = 1'b1;
            if (in_eol) begin
                col_d = '0;
                row_d = (curRow == RW'(KMAX)) ? curRow : curRow + 1'b1;
                buf_d = (curBuf == BW'(NBUF - 1)) ? '0 : curBuf + 1'b1;
            end else begin
                col_d = drop ? curCol : curCol + 1'b1;
                row_d = curRow;
                buf_d = curBuf;
            end
        end
    end

    always_comb begin
        hSum = '0;
        for (int i = 0; i < KMAX; i++) begin
            hSum = hSum + HW'(hTap_q[i]) * HW'(coef(s1Mode_q, i));
        end
    end

    // Vertical tap j lives in the buffer written j rows ago (ring of NBUF buffers).
    always_comb begin
        idx  = '0;
        vSum = VW'(hSum_q) * VW'(coef(s2Mode_q, 0));
        for (int j = 1; j < KMAX; j++) begin
            idx  = (s2Buf_q >= BW'(j)) ? s2Buf_q - BW'(j) : s2Buf_q + BW'(NBUF - j);
            vSum = vSum + VW'(rd_q[idx]) * VW'(coef(s2Mode_q, j));
        end
        vRnd = vSum + (s2Mode_q ? RND11 : RND5);
    end

    // Read-before-write: the buffer being overwritten still yields the row KMAX-1 lines back.
    always_ff @(posedge clk) begin
        if (s1Valid_q) begin
            lineBuf[s1Buf_q][s1Col_q] <= hSum;
            for (int b = 0; b < NBUF; b++) begin
                rd_q[b] <= lineBuf[b][s1Col_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            buf_q      <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < KMAX; i++) hTap_q[i] <= '0;
            s1Valid_q  <= 1'b0;
            s1Mode_q   <= 1'b0;
            s1Win_q    <= 1'b0;
            s1Sof_q    <= 1'b0;
            s1Eol_q    <= 1'b0;
            s1Col_q    <= '0;
            s1Buf_q    <= '0;
            hSum_q     <= '0;
            s2Mode_q   <= 1'b0;
            s2Win_q    <= 1'b0;
            s2Sof_q    <= 1'b0;
            s2Eol_q    <= 1'b0;
            s2Buf_q    <= '0;
            outValid_q <= 1'b0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
            outPix_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            buf_q     <= buf_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            if (accept) begin
                hTap_q[0] <= in_pix;
                for (int i = KMAX - 1; i > 0; i--) begin
                    hTap_q[i] <= (curCol == '0) ? '0 : hTap_q[i-1];
                end
            end
            s1Valid_q  <= accept;
            s1Mode_q   <= curMode;
            s1Win_q    <= win;
            s1Sof_q    <= winSof;
            s1Eol_q    <= win && in_eol;
            s1Col_q    <= curCol;
            s1Buf_q    <= curBuf;
            hSum_q     <= hSum;
            s2Mode_q   <= s1Mode_q;
            s2Win_q    <= s1Win_q;
            s2Sof_q    <= s1Sof_q;
            s2Eol_q    <= s1Eol_q;
            s2Buf_q    <= s1Buf_q;
            outValid_q <= s2Win_q;
            outSof_q   <= s2Sof_q;
            outEol_q   <= s2Eol_q;
            outPix_q   <= s2Win_q ? PIX_W'(vRnd >> (s2Mode_q ? 20 : 8)) : '0;
        end
    end

    assign out_valid = outValid_q;
    assign out_sof   = outSof_q;
    assign out_eol   = outEol_q;
    assign out_pix   = outPix_q;
    assign err_len   = err_q;

endmodule
